alu32: RTL and testbench
========================

Name: alu32

Overview:
- 32-bit registered integer ALU for the datapath execute stage. MIPS-style operation set: add/sub (signed/unsigned), logic ops, set-less-than, shifts.
- Operation is selected by a 4-bit primary opcode (op1), or by a 4-bit secondary function code (op) when op1 escapes.
- Result and flags (carryout, overflow, zero) are registered, with one cycle of latency.

Parameters:
- WIDTH, 32, datapath width; all behaviour below is specified for 32, and other values are not supported.

Ports:
- clk       input   1   rising-edge clock
- rst       input   1   synchronous reset, active-high
- op1       input   4   primary opcode; 4'hF selects secondary decode from op
- op        input   4   secondary function code; used only when op1 == 4'hF
- in0       input   32  operand A; value being shifted for shifts
- in1       input   32  operand B; shift amount in in1[4:0] for shifts
- carryout  output  1   unsigned carry (add) / borrow (sub)
- overflow  output  1   signed two's-complement overflow (ADD/SUB only)
- zero      output  1   1 when the result is 32'h0
- out       output  32  result

Behaviour:
- Effective code: eff = (op1 == 4'hF) ? op : op1. Encoding for eff:
  - 0 ADD: in0+in1
  - 1 ADDU: in0+in1
  - 2 SUB: in0-in1
  - 3 SUBU: in0-in1
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 NOR: ~(in0|in1)
  - 8 SLT: signed in0<in1 ? 1 : 0
  - 9 SLTU: unsigned compare, same result form as SLT
  - A SLL: in0 << in1[4:0]
  - B SRL: logical right shift
  - C SRA: arithmetic right shift, sign bit of in0 replicated
  - D LUI: {in1[15:0],16'h0}
  - E PASS: in1
  - F (reachable only when op1=F and op=F): out = 0
- Flags:
  - carryout: ADD/ADDU = bit 32 of the 33-bit sum. SUB/SUBU = borrow, i.e. 1 when unsigned in0 < in1. All other ops = 0.
  - overflow: ADD = operand signs equal and result sign differs. SUB = operand signs differ and result sign differs from in0. ADDU, SUBU and all other ops = 0.
  - On overflow the wrapped result is still written to out; there is no trap.
  - zero = (result == 0), evaluated for every op, including SLT results and the eff=F case.
- Timing:
  - Fully combinational compute, with one register stage.
  - Inputs sampled at posedge N appear on out/flags after posedge N; latency is 1 cycle and throughput is one op per cycle, with no handshake.
- Reset:
  - rst sampled high at posedge: out=0, carryout=0, overflow=0, zero=0.
  - Reset has priority over any operation issued the same cycle; an operation in flight is discarded.
- X/undefined op with a valid op1 (op1 != F): op is ignored, and the result must be independent of op.
- Shift amounts use only in1[4:0]; in1[31:5] is ignored. A shift by 0 returns in0.

Decomposition:
- Shared package alu32_pkg: WIDTH constant, opcode constants (ALU_ADD..ALU_PASS, ALU_ESC = 4'hF).
- One sub-module is natural: alu32_shifter, a combinational barrel shifter with inputs in0, shamt[4:0], mode (SLL/SRL/SRA) and a 32-bit result.
- Adder/subtractor, logic, compare and result/flag registers stay in alu32.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> out=0, carryout=0, overflow=0, zero=0; deassert, and the first op appears one cycle later.
- Signed overflow: op1=0 (ADD), op=X, in0=7fffffff, in1=00000001 -> out=80000000, overflow=1, carryout=0, zero=0.
- Unsigned add: op1=1 (ADDU), in0=0000000f, in1=7fffffff -> out=8000000e, overflow=0, carryout=0. Then in0=ffffffff, in1=00000001 -> out=0, carryout=1, zero=1, overflow=0.
- Signed subtract overflow: op1=2 (SUB), in0=f0000000, in1=7fffffff -> out=70000001, overflow=1, carryout=0. Then in0=ffffffff, in1=ffffffff -> out=0, zero=1.
- Escape decode and compare: op1=F with op=8 (SLT), in0=f0001231, in1=7ac34545 -> out=1. With op=9 (SLTU), same operands -> out=0, zero=1.
- Shifts/logic via op1:
  - SLL in0=ffffffff, in1=5 -> ffffffe0
  - SRL -> 07ffffff
  - SRA in0=ffffffff, in1=3 -> ffffffff
  - SRA in0=0fffffff, in1=5 -> 007fffff
  - NOR in0=7fffffff, in1=f0000001 -> 00000000, zero=1

Source files
------------

// File: rtl/alu32_pkg.sv
// Shared constants and opcode encodings for the alu32 execute-stage ALU.
package alu32_pkg;

  localparam int WIDTH     = 32;
  localparam int SHAMT_W   = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_ADDU = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_SUBU = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_SLL  = 4'hA,
    ALU_SRL  = 4'hB,
    ALU_SRA  = 4'hC,
    ALU_LUI  = 4'hD,
    ALU_PASS = 4'hE,
    ALU_ESC  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

endpackage

// File: rtl/alu32_shifter.sv
// Combinational 32-bit barrel shifter: logical left, logical right, arithmetic right.
module alu32_shifter
  import alu32_pkg::*;
(
  input  logic [WIDTH-1:0]   in0_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_mode_e        mode_i,
  output logic [WIDTH-1:0]   res_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    res_o = in0_i;
    unique case (mode_i)
      SH_SLL:  res_o = in0_i << shamt_i;
      SH_SRL:  res_o = in0_i >> shamt_i;
      SH_SRA:  res_o = $unsigned($signed(in0_i) >>> shamt_i);
      default: res_o = in0_i;
    endcase
  end

endmodule

// File: rtl/alu32.sv
// Registered 32-bit MIPS-style ALU: primary/escape opcode decode, one-cycle latency.
module alu32
  import alu32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op1,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] out
);

  alu_op_e          eff;
  shift_mode_e      sh_mode;
  logic [WIDTH-1:0] sh_res;
  logic [WIDTH:0]   sum33;
  logic [WIDTH:0]   diff33;
  logic             add_ovf;
  logic             sub_ovf;

  logic [WIDTH-1:0] out_d, out_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  // op only matters on the escape code, so X on op cannot leak into a primary op.
  assign eff = alu_op_e'((op1 == ALU_ESC) ? op : op1);

  assign sum33  = {1'b0, in0} + {1'b0, in1};
  assign diff33 = {1'b0, in0} - {1'b0, in1};

  assign add_ovf = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum33[WIDTH-1]  != in0[WIDTH-1]);
  assign sub_ovf = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff33[WIDTH-1] != in0[WIDTH-1]);

  always_comb begin
    sh_mode = SH_SRA;
    if (eff == ALU_SLL)      sh_mode = SH_SLL;
    else if (eff == ALU_SRL) sh_mode = SH_SRL;
  end

  alu32_shifter u_shifter (
    .in0_i   (in0),
    .shamt_i (in1[SHAMT_W-1:0]),
    .mode_i  (sh_mode),
    .res_o   (sh_res)
  );

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (eff)
      ALU_ADD:  begin out_d = sum33[WIDTH-1:0];  carry_d = sum33[WIDTH];  ovf_d = add_ovf; end
      ALU_ADDU: begin out_d = sum33[WIDTH-1:0];  carry_d = sum33[WIDTH];  end
      ALU_SUB:  begin out_d = diff33[WIDTH-1:0]; carry_d = diff33[WIDTH]; ovf_d = sub_ovf; end
      ALU_SUBU: begin out_d = diff33[WIDTH-1:0]; carry_d = diff33[WIDTH]; end
      ALU_AND:  out_d = in0 & in1;
      ALU_OR:   out_d = in0 | in1;
      ALU_XOR:  out_d = in0 ^ in1;
      ALU_NOR:  out_d = ~(in0 | in1);
      ALU_SLT:  out_d = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      ALU_SLTU: out_d = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      ALU_SLL, ALU_SRL, ALU_SRA: out_d = sh_res;
      ALU_LUI:  out_d = {in1[15:0], 16'h0000};
      ALU_PASS: out_d = in1;
      default:  out_d = '0;
    endcase
    zero_d = (out_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out      = out_q;
  assign carryout = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_alu32.sv
// Directed, table-driven self-checking bench for alu32.
module tb_alu32;

  typedef struct {
    logic [3:0]  op1;
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp_out;
    logic        exp_c;
    logic        exp_v;
    logic        exp_z;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op1;
  logic [3:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  alu32 dut (
    .clk      (clk),
    .rst      (rst),
    .op1      (op1),
    .op       (op),
    .in0      (in0),
    .in1      (in1),
    .carryout (carryout),
    .overflow (overflow),
    .zero     (zero),
    .out      (out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_out,
                           input logic e_c, input logic e_v, input logic e_z);
    check({tag, ".out"},      out,              e_out);
    check({tag, ".carryout"}, {31'b0, carryout}, {31'b0, e_c});
    check({tag, ".overflow"}, {31'b0, overflow}, {31'b0, e_v});
    check({tag, ".zero"},     {31'b0, zero},     {31'b0, e_z});
  endtask

  task automatic drive(input logic [3:0] a_op1, input logic [3:0] a_op,
                       input logic [31:0] a_in0, input logic [31:0] a_in1);
    op1 = a_op1;
    op  = a_op;
    in0 = a_in0;
    in1 = a_in1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               op1    op     in0           in1           out           c     v     z
    vq.push_back('{4'h0, 4'h7, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'h0, 4'h2, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1});
    vq.push_back('{4'h1, 4'h3, 32'h0000000f, 32'h7fffffff, 32'h8000000e, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h1, 4'h0, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1});
    vq.push_back('{4'h1, 4'h9, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h2, 4'hc, 32'hf0000000, 32'h7fffffff, 32'h70000001, 1'b0, 1'b1, 1'b0});
    vq.push_back('{4'h2, 4'h1, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vq.push_back('{4'h2, 4'h5, 32'h00000001, 32'h00000002, 32'hffffffff, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'h3, 4'h0, 32'h00000001, 32'h00000002, 32'hffffffff, 1'b1, 1'b0, 1'b0});
    vq.push_back('{4'h3, 4'h2, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h4, 4'h0, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h5, 4'h0, 32'hf0f0f0f0, 32'h0f0f0000, 32'hfffff0f0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h6, 4'h0, 32'haaaaaaaa, 32'hffffffff, 32'h55555555, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h7, 4'h0, 32'h7fffffff, 32'hf0000001, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vq.push_back('{4'hf, 4'h8, 32'hf0001231, 32'h7ac34545, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hf, 4'h9, 32'hf0001231, 32'h7ac34545, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vq.push_back('{4'h8, 4'h0, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vq.push_back('{4'h8, 4'h0, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'h9, 4'h0, 32'h00000001, 32'hffffffff, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'ha, 4'h0, 32'hffffffff, 32'h00000005, 32'hffffffe0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'ha, 4'h0, 32'h00000001, 32'hffffffff, 32'h80000000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hb, 4'h0, 32'hffffffff, 32'h00000005, 32'h07ffffff, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hb, 4'h0, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hc, 4'h0, 32'hffffffff, 32'h00000003, 32'hffffffff, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hc, 4'h0, 32'h0fffffff, 32'h00000005, 32'h007fffff, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hc, 4'h0, 32'h80000000, 32'h0000001f, 32'hffffffff, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hd, 4'h0, 32'h00000000, 32'h1234abcd, 32'habcd0000, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hd, 4'h0, 32'h55555555, 32'hffff0000, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vq.push_back('{4'he, 4'h0, 32'h11111111, 32'hdeadbeef, 32'hdeadbeef, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hf, 4'hf, 32'h12345678, 32'h9abcdef0, 32'h00000000, 1'b0, 1'b0, 1'b1});
    vq.push_back('{4'hf, 4'h0, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0});
    vq.push_back('{4'hf, 4'hc, 32'h80000000, 32'h00000004, 32'hf8000000, 1'b0, 1'b0, 1'b0});

    // Reset held for two cycles with an op that would otherwise produce a nonzero result.
    rst = 1'b1;
    drive(4'h0, 4'h0, 32'hffffffff, 32'h00000001);
    tick();
    drive(4'h2, 4'h0, 32'h00000001, 32'h00000002);
    tick();
    check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);

    // First op after deassert appears exactly one cycle later.
    rst = 1'b0;
    drive(4'h0, 4'h0, 32'h00000002, 32'h00000003);
    #3;
    check("post_reset_hold.out", out, 32'h0);
    tick();
    check_all("first_op", 32'h00000005, 1'b0, 1'b0, 1'b0);

    // Reset wins over an op issued in the same cycle and clears a live result.
    drive(4'he, 4'h0, 32'h0, 32'hdeadbeef);
    tick();
    check("pre_rst.out", out, 32'hdeadbeef);
    rst = 1'b1;
    drive(4'h0, 4'h0, 32'h7fffffff, 32'h00000001);
    tick();
    check_all("rst_priority", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back vectors, one per cycle.
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].op1, vq[i].op, vq[i].in0, vq[i].in1);
      tick();
      check_all($sformatf("vec%0d", i), vq[i].exp_out, vq[i].exp_c, vq[i].exp_v, vq[i].exp_z);
    end

    // Primary ADD must not depend on op.
    for (int k = 0; k < 16; k++) begin
      drive(4'h0, 4'(k), 32'h40000000, 32'h40000000);
      tick();
      check_all($sformatf("add_op%0d", k), 32'h80000000, 1'b0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
